// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-port arbiter: control codes and FSM encoding.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU: AND/ORR/ADD/SUB/PASS B with zero flag; other codes produce zero.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CTRLW = 4
) (
    output logic [WIDTH-1:0] busW,
    output logic             zero,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    input  logic [CTRLW-1:0] ctrl
);

    always_comb begin
        busW = '0;
        case (ctrl)
            ALU_AND:   busW = busA & busB;
            ALU_ORR:   busW = busA | busB;
            ALU_ADD:   busW = busA + busB;
            ALU_SUB:   busW = busA - busB;
            ALU_PASSB: busW = busB;
            default:   busW = '0;
        endcase
    end

    assign zero = (busW == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters, one op in flight at a time.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CTRLW = 4
) (
    input  logic             CLK,
    input  logic             resetl,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [CTRLW-1:0] req0_ctrl,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_busW,
    output logic             rsp0_zero,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [CTRLW-1:0] req1_ctrl,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_busW,
    output logic             rsp1_zero
);

    state_e             r_state, w_next_state;
    logic               r_last_grant, r_owner;
    logic [WIDTH-1:0]   r_op_a, r_op_b;
    logic [CTRLW-1:0]   r_op_ctrl;
    logic               r_rsp0_valid, r_rsp0_zero, r_rsp1_valid, r_rsp1_zero;
    logic [WIDTH-1:0]   r_rsp0_busW, r_rsp1_busW;
    logic               w_any_valid, w_grant, w_rsp_ack, w_alu_zero;
    logic [WIDTH-1:0]   w_alu_busW;

    assign w_any_valid = req0_valid | req1_valid;
    // On a tie the port that did not win last time gets the grant.
    assign w_grant     = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
    assign w_rsp_ack   = r_owner ? rsp1_ready : rsp0_ready;

    alu #(
        .WIDTH (WIDTH),
        .CTRLW (CTRLW)
    ) u_alu (
        .busW (w_alu_busW),
        .zero (w_alu_zero),
        .busA (r_op_a),
        .busB (r_op_b),
        .ctrl (r_op_ctrl)
    );

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) r_state <= IDLE;
        else         r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (w_any_valid) w_next_state = EXEC;
            EXEC:    w_next_state = RESP;
            RESP:    if (w_rsp_ack) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (r_state == IDLE && w_any_valid) begin
            req0_ready = ~w_grant;
            req1_ready = w_grant;
        end
    end

    assign rsp0_valid = r_rsp0_valid;
    assign rsp0_busW  = r_rsp0_busW;
    assign rsp0_zero  = r_rsp0_zero;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp1_busW  = r_rsp1_busW;
    assign rsp1_zero  = r_rsp1_zero;

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_op_ctrl    <= '0;
            r_rsp0_valid <= 1'b0;
            r_rsp0_busW  <= '0;
            r_rsp0_zero  <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp1_busW  <= '0;
            r_rsp1_zero  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_any_valid) begin
                        r_op_a       <= w_grant ? req1_a    : req0_a;
                        r_op_b       <= w_grant ? req1_b    : req0_b;
                        r_op_ctrl    <= w_grant ? req1_ctrl : req0_ctrl;
                        r_owner      <= w_grant;
                        r_last_grant <= w_grant;
                    end
                end
                EXEC: begin
                    if (r_owner) begin
                        r_rsp1_busW  <= w_alu_busW;
                        r_rsp1_zero  <= w_alu_zero;
                        r_rsp1_valid <= 1'b1;
                    end else begin
                        r_rsp0_busW  <= w_alu_busW;
                        r_rsp0_zero  <= w_alu_zero;
                        r_rsp0_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (w_rsp_ack) begin
                        if (r_owner) r_rsp1_valid <= 1'b0;
                        else         r_rsp0_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized round-robin traffic.
module tb_alu_arbiter;

    localparam int WIDTH = 64;
    localparam int CTRLW = 4;

    logic             CLK, resetl;
    logic             req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero;
    logic             req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b, rsp0_busW, rsp1_busW;
    logic [CTRLW-1:0] req0_ctrl, req1_ctrl;

    int n_tests = 0;
    int n_fail  = 0;
    int rr_last = 1;

    alu_arbiter #(
        .WIDTH (WIDTH),
        .CTRLW (CTRLW)
    ) dut (
        .CLK        (CLK),
        .resetl     (resetl),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ctrl  (req0_ctrl),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_busW  (rsp0_busW),
        .rsp0_zero  (rsp0_zero),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ctrl  (req1_ctrl),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_busW  (rsp1_busW),
        .rsp1_zero  (rsp1_zero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference ALU straight from the operation table.
    function automatic logic [WIDTH-1:0] model(input logic [3:0] c, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return b;
            default: return '0;
        endcase
    endfunction

    function automatic logic rdy(input int p);
        return (p == 1) ? req1_ready : req0_ready;
    endfunction

    function automatic logic rvalid(input int p);
        return (p == 1) ? rsp1_valid : rsp0_valid;
    endfunction

    function automatic logic [WIDTH-1:0] rbus(input int p);
        return (p == 1) ? rsp1_busW : rsp0_busW;
    endfunction

    function automatic logic rzero(input int p);
        return (p == 1) ? rsp1_zero : rsp0_zero;
    endfunction

    task automatic drive_req(input int p, input logic v, input logic [3:0] c,
                             input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (p == 1) begin
            req1_valid = v; req1_ctrl = c; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_ctrl = c; req0_a = a; req0_b = b;
        end
    endtask

    task automatic set_rsp_ready(input int p, input logic v);
        if (p == 1) rsp1_ready = v;
        else        rsp0_ready = v;
    endtask

    task automatic apply_reset();
        resetl = 1'b0;
        req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
        req0_a = '0; req0_b = '0; req0_ctrl = '0;
        req1_a = '0; req1_b = '0; req1_ctrl = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        resetl = 1'b1;
        rr_last = 1;
        #1;
    endtask

    // Waits (bounded) for port p's ready, checks the other port is not granted, takes the edge.
    task automatic accept(input int p, input string name);
        int cnt = 0;
        while (!rdy(p) && cnt < 20) begin
            @(negedge CLK); #1; cnt++;
        end
        n_tests++;
        if (rdy(p) !== 1'b1 || rdy(1 - p) !== 1'b0) begin
            n_fail++;
            $display("FAIL %s accept: ready%0d=%b ready%0d=%b, required 1/0",
                     name, p, rdy(p), 1 - p, rdy(1 - p));
        end
        @(posedge CLK); #1;
        drive_req(p, 1'b0, 4'h0, '0, '0);
        rr_last = p;
    endtask

    // Called #1 after the accept edge: checks EXEC, RESP data, optional stall, then handshakes.
    task automatic finish_op(input int p, input logic [WIDTH-1:0] exp, input int stall,
                             input string name);
        n_tests++;
        if (rvalid(p) !== 1'b0) begin
            n_fail++;
            $display("FAIL %s early rsp: rsp%0d_valid=%b, required 0", name, p, rvalid(p));
        end
        @(posedge CLK); #1;
        n_tests++;
        if (rvalid(p) !== 1'b1 || rbus(p) !== exp || rzero(p) !== (exp == '0)
            || rvalid(1 - p) !== 1'b0) begin
            n_fail++;
            $display("FAIL %s rsp: valid=%b busW=%h zero=%b other_valid=%b, required 1 %h %b 0",
                     name, rvalid(p), rbus(p), rzero(p), rvalid(1 - p), exp, (exp == '0));
        end
        repeat (stall) begin
            @(posedge CLK); #1;
            n_tests++;
            if (rvalid(p) !== 1'b1 || rbus(p) !== exp) begin
                n_fail++;
                $display("FAIL %s stall hold: valid=%b busW=%h, required 1 %h",
                         name, rvalid(p), rbus(p), exp);
            end
        end
        set_rsp_ready(p, 1'b1);
        @(posedge CLK); #1;
        set_rsp_ready(p, 1'b0);
        n_tests++;
        if (rvalid(p) !== 1'b0) begin
            n_fail++;
            $display("FAIL %s rsp clear: rsp%0d_valid=%b, required 0", name, p, rvalid(p));
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++;
        if (rsp0_valid !== 0 || rsp1_valid !== 0) begin
            n_fail++;
            $display("FAIL reset valid: %b %b, required 0 0", rsp0_valid, rsp1_valid);
        end
        n_tests++;
        if (rsp0_busW !== '0 || rsp1_busW !== '0 || rsp0_zero !== 0 || rsp1_zero !== 0) begin
            n_fail++;
            $display("FAIL reset data: %h %h %b %b, required zeros",
                     rsp0_busW, rsp1_busW, rsp0_zero, rsp1_zero);
        end
        n_tests++;
        if (req0_ready !== 0 || req1_ready !== 0) begin
            n_fail++;
            $display("FAIL reset ready: %b %b, required 0 0", req0_ready, req1_ready);
        end
    endtask

    task automatic test_add();
        logic [WIDTH-1:0] a = 64'h82C639269A;
        logic [WIDTH-1:0] b = 64'h152672E37E;
        @(negedge CLK);
        drive_req(0, 1'b1, 4'b0010, a, b);
        #1;
        n_tests++;
        if (req0_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL add first-cycle ready: %b, required 1", req0_ready);
        end
        accept(0, "add");
        finish_op(0, 64'h97ECAC0A18, 0, "add");
    endtask

    task automatic test_both_valid();
        logic [WIDTH-1:0] a = 64'h7F0C4B3F;
        logic [WIDTH-1:0] b = 64'h5A0E7A39;
        apply_reset();
        for (int rep = 0; rep < 2; rep++) begin
            @(negedge CLK);
            drive_req(0, 1'b1, 4'b0110, a, b);
            drive_req(1, 1'b1, 4'b0000, a, b);
            #1;
            accept(0, "both p0");
            finish_op(0, 64'h24FDD106, rep, "both p0");
            accept(1, "both p1");
            finish_op(1, 64'h5A0C4A39, 0, "both p1");
        end
    endtask

    task automatic test_passb_zero();
        @(negedge CLK);
        drive_req(1, 1'b1, 4'b0111, 64'h82C639269A, '0);
        #1;
        accept(1, "passb");
        finish_op(1, '0, 1, "passb");
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] exp0 = model(4'b0010, 64'h1234, 64'h4321);
        @(negedge CLK);
        drive_req(0, 1'b1, 4'b0010, 64'h1234, 64'h4321);
        #1;
        accept(0, "bp p0");
        drive_req(1, 1'b1, 4'b0001, 64'hF0, 64'h0F);
        @(posedge CLK); #1;
        n_tests++;
        if (rsp0_valid !== 1'b1 || rsp0_busW !== exp0) begin
            n_fail++;
            $display("FAIL bp rsp0: valid=%b busW=%h, required 1 %h", rsp0_valid, rsp0_busW, exp0);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK); #1;
            n_tests++;
            if (rsp0_valid !== 1'b1 || rsp0_busW !== exp0 || req1_ready !== 1'b0
                || rsp1_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL bp hold %0d: valid=%b busW=%h req1_ready=%b rsp1_valid=%b", i,
                         rsp0_valid, rsp0_busW, req1_ready, rsp1_valid);
            end
        end
        rsp0_ready = 1'b1;
        @(posedge CLK); #1;
        rsp0_ready = 1'b0;
        n_tests++;
        if (rsp0_valid !== 1'b0 || req1_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp release: rsp0_valid=%b req1_ready=%b, required 0 1",
                     rsp0_valid, req1_ready);
        end
        accept(1, "bp p1");
        finish_op(1, 64'hFF, 0, "bp p1");
    endtask

    task automatic test_reset_mid();
        @(negedge CLK);
        drive_req(0, 1'b1, 4'b0001, 64'hA5, 64'h5A00);
        #1;
        accept(0, "rst ORR");
        resetl = 1'b0;
        #1;
        n_tests++;
        if (rsp0_valid !== 0 || rsp1_valid !== 0 || rsp0_busW !== '0 || rsp1_busW !== '0) begin
            n_fail++;
            $display("FAIL rst async: valid %b %b busW %h %h, required 0 0 0 0",
                     rsp0_valid, rsp1_valid, rsp0_busW, rsp1_busW);
        end
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        resetl = 1'b1;
        rr_last = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            n_tests++;
            if (rsp0_valid !== 0 || rsp1_valid !== 0) begin
                n_fail++;
                $display("FAIL rst no-rsp %0d: %b %b, required 0 0", i, rsp0_valid, rsp1_valid);
            end
        end
        @(negedge CLK);
        drive_req(0, 1'b1, 4'b0010, 64'd7, 64'd8);
        drive_req(1, 1'b1, 4'b0110, 64'd7, 64'd7);
        #1;
        accept(0, "rst prio p0");
        finish_op(0, 64'd15, 0, "rst prio p0");
        accept(1, "rst prio p1");
        finish_op(1, '0, 0, "rst prio p1");
    endtask

    task automatic test_random();
        logic [3:0]       codes [5];
        logic [3:0]       c [2];
        logic [WIDTH-1:0] a [2];
        logic [WIDTH-1:0] b [2];
        logic             pend [2];
        int               w;
        codes[0] = 4'b0000; codes[1] = 4'b0001; codes[2] = 4'b0010;
        codes[3] = 4'b0110; codes[4] = 4'b0111;
        for (int it = 0; it < 40; it++) begin
            int sel = $urandom_range(1, 3);
            @(negedge CLK);
            for (int p = 0; p < 2; p++) begin
                pend[p] = sel[p];
                c[p] = codes[$urandom_range(0, 4)];
                a[p] = {$urandom, $urandom};
                b[p] = ($urandom_range(0, 7) == 0) ? a[p] : {$urandom, $urandom};
                if (pend[p]) drive_req(p, 1'b1, c[p], a[p], b[p]);
            end
            #1;
            while (pend[0] || pend[1]) begin
                if (pend[0] && pend[1]) w = 1 - rr_last;
                else                    w = pend[1] ? 1 : 0;
                accept(w, "rand");
                finish_op(w, model(c[w], a[w], b[w]), $urandom_range(0, 3), "rand");
                pend[w] = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_both_valid();
        test_passb_zero();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
